// File: rtl/llc_input_arbiter_pkg.sv
// Shared LLC input-arbiter constants: channel select codes, FSM states, output entry layout.
package llc_input_arbiter_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NUM_CH = 4;

    localparam logic [SEL_W-1:0] SEL_RST_TB     = 2'd0;
    localparam logic [SEL_W-1:0] SEL_RSP_IN     = 2'd1;
    localparam logic [SEL_W-1:0] SEL_REQ_IN     = 2'd2;
    localparam logic [SEL_W-1:0] SEL_DMA_REQ_IN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DMA_BURST = 2'd1,
        ST_RST_WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] sel;
        logic             last;
    } out_entry_t;

    // Priority slot -> channel code; a starved DMA trades places with req_in.
    function automatic logic [SEL_W-1:0] slot_to_sel(input logic [SEL_W-1:0] slot,
                                                     input logic dma_boost);
        if (dma_boost && slot == SEL_REQ_IN)     return SEL_DMA_REQ_IN;
        if (dma_boost && slot == SEL_DMA_REQ_IN) return SEL_REQ_IN;
        return slot;
    endfunction

endpackage

// File: rtl/llc_input_arbiter_prio_sel.sv
// Masked fixed-priority select: lowest-index eligible request wins.
module llc_prio_sel
    import llc_input_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    output logic [NUM_CH-1:0] gnt_oh,
    output logic [SEL_W-1:0]  gnt_code,
    output logic              gnt_any
);

    logic [NUM_CH-1:0] eligible;

    always_comb begin
        eligible = req & mask;
        gnt_oh   = '0;
        gnt_code = '0;
        gnt_any  = 1'b0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                gnt_oh    = '0;
                gnt_oh[i] = 1'b1;
                gnt_code  = SEL_W'(i);
                gnt_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC pipeline input arbiter: four request channels into one registered grant entry,
// with DMA burst locking, reset-to-baseline drain and DMA anti-starvation.
module llc_input_arbiter
    import llc_input_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_tb_valid,
    output logic             rst_tb_ready,
    input  logic             rsp_in_valid,
    output logic             rsp_in_ready,
    input  logic             req_in_valid,
    output logic             req_in_ready,
    input  logic             dma_req_in_valid,
    output logic             dma_req_in_ready,
    input  logic             dma_last,
    input  logic             req_stall,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_last,
    output logic             dma_locked
);

    arb_state_e        state, state_nxt;
    out_entry_t        entry;
    logic [CNT_W-1:0]  starve_cnt;
    logic              accept, consumed, dma_boost, grant_en;
    logic [NUM_CH-1:0] ch_req, ch_mask, ch_elig, ch_gnt;
    logic [NUM_CH-1:0] slot_req, slot_oh;
    logic [SEL_W-1:0]  slot_code, gnt_sel;
    logic              gnt_any;

    assign accept    = !entry.valid || out_ready;
    assign consumed  = entry.valid && out_ready;
    assign grant_en  = accept && !rst;
    assign dma_boost = (starve_cnt == CNT_W'(STARVE_MAX));
    assign ch_req    = {dma_req_in_valid, req_in_valid & ~req_stall, rsp_in_valid, rst_tb_valid};
    assign ch_elig   = ch_req & ch_mask;

    // Channel order <-> priority slot order; starved DMA swaps with req_in.
    always_comb begin
        slot_req = ch_elig;
        ch_gnt   = slot_oh;
        if (dma_boost) begin
            slot_req[SEL_REQ_IN]     = ch_elig[SEL_DMA_REQ_IN];
            slot_req[SEL_DMA_REQ_IN] = ch_elig[SEL_REQ_IN];
            ch_gnt[SEL_REQ_IN]       = slot_oh[SEL_DMA_REQ_IN];
            ch_gnt[SEL_DMA_REQ_IN]   = slot_oh[SEL_REQ_IN];
        end
    end

    llc_prio_sel u_prio_sel (
        .req      (slot_req),
        .mask     ({NUM_CH{grant_en}}),
        .gnt_oh   (slot_oh),
        .gnt_code (slot_code),
        .gnt_any  (gnt_any)
    );

    assign gnt_sel          = slot_to_sel(slot_code, dma_boost);
    assign rst_tb_ready     = ch_gnt[SEL_RST_TB];
    assign rsp_in_ready     = ch_gnt[SEL_RSP_IN];
    assign req_in_ready     = ch_gnt[SEL_REQ_IN];
    assign dma_req_in_ready = ch_gnt[SEL_DMA_REQ_IN];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DMA_BURST: begin
                if (gnt_any && gnt_sel == SEL_RST_TB)
                    state_nxt = ST_RST_WAIT;
                else if (gnt_any && gnt_sel == SEL_DMA_REQ_IN)
                    state_nxt = dma_last ? ST_IDLE : ST_DMA_BURST;
            end
            ST_RST_WAIT: begin
                if (consumed && entry.sel == SEL_RST_TB) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-state channel eligibility.
    always_comb begin
        ch_mask    = '0;
        dma_locked = (state == ST_DMA_BURST);
        case (state)
            ST_IDLE: ch_mask = '1;
            ST_DMA_BURST: begin
                ch_mask[SEL_RSP_IN]     = 1'b1;
                ch_mask[SEL_DMA_REQ_IN] = 1'b1;
            end
            default: ch_mask = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry      <= '0;
            starve_cnt <= '0;
        end else begin
            if (gnt_any) begin
                entry.valid <= 1'b1;
                entry.sel   <= gnt_sel;
                entry.last  <= (gnt_sel == SEL_DMA_REQ_IN) && dma_last;
            end else if (consumed) begin
                entry.valid <= 1'b0;
            end
            if (gnt_any && gnt_sel == SEL_DMA_REQ_IN)
                starve_cnt <= '0;
            else if (gnt_any && gnt_sel == SEL_REQ_IN && dma_req_in_valid && !dma_boost)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign out_valid = entry.valid;
    assign out_sel   = entry.sel;
    assign out_last  = entry.last;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Randomized and directed bench for llc_input_arbiter against a transaction-level model.
module tb_llc_input_arbiter;

    localparam int STARVE_MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_tb_valid, rst_tb_ready;
    logic       rsp_in_valid, rsp_in_ready;
    logic       req_in_valid, req_in_ready;
    logic       dma_req_in_valid, dma_req_in_ready;
    logic       dma_last, req_stall;
    logic       out_valid, out_ready;
    logic [1:0] out_sel;
    logic       out_last, dma_locked;

    always #5 clk = ~clk;

    llc_input_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk              (clk),
        .rst              (rst),
        .rst_tb_valid     (rst_tb_valid),
        .rst_tb_ready     (rst_tb_ready),
        .rsp_in_valid     (rsp_in_valid),
        .rsp_in_ready     (rsp_in_ready),
        .req_in_valid     (req_in_valid),
        .req_in_ready     (req_in_ready),
        .dma_req_in_valid (dma_req_in_valid),
        .dma_req_in_ready (dma_req_in_ready),
        .dma_last         (dma_last),
        .req_stall        (req_stall),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sel          (out_sel),
        .out_last         (out_last),
        .dma_locked       (dma_locked)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=idle 1=burst 2=wait-for-reset-drain.
    int m_mode, m_cnt, m_sel;
    bit m_valid, m_last;

    // Source side: pending transfers per channel, DMA beats as last-flags.
    int n_rst, n_rsp, n_req;
    bit dma_q[$];
    int obs_q[$];
    bit [3:0] last_ready;

    function automatic bit chan_valid(input int ch);
        case (ch)
            0: return rst_tb_valid;
            1: return rsp_in_valid;
            2: return req_in_valid && !req_stall;
            default: return dma_req_in_valid;
        endcase
    endfunction

    function automatic int model_pick();
        int order[4];
        int n;
        if (rst || m_mode == 2 || (m_valid && !out_ready)) return -1;
        if (m_mode == 1) begin
            order = '{1, 3, 0, 0};
            n = 2;
        end else if (m_cnt == STARVE_MAX) begin
            order = '{0, 1, 3, 2};
            n = 4;
        end else begin
            order = '{0, 1, 2, 3};
            n = 4;
        end
        for (int i = 0; i < n; i++)
            if (chan_valid(order[i])) return order[i];
        return -1;
    endfunction

    task automatic model_update(input int g);
        bit consumed;
        consumed = m_valid && out_ready;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_valid = 0; m_sel = 0; m_last = 0;
            return;
        end
        if (m_mode == 2) begin
            if (consumed && m_sel == 0) m_mode = 0;
        end else if (g == 0) m_mode = 2;
        else if (g == 3) m_mode = dma_last ? 0 : 1;
        if (g == 3) m_cnt = 0;
        else if (g == 2 && dma_req_in_valid && m_cnt < STARVE_MAX) m_cnt++;
        if (g >= 0) begin
            m_valid = 1; m_sel = g; m_last = (g == 3) && dma_last;
        end else if (consumed) m_valid = 0;
    endtask

    task automatic cycle();
        int g;
        bit [3:0] rdy, exp_rdy;
        rst_tb_valid     = (n_rst > 0);
        rsp_in_valid     = (n_rsp > 0);
        req_in_valid     = (n_req > 0);
        dma_req_in_valid = (dma_q.size() > 0);
        dma_last         = (dma_q.size() > 0) ? dma_q[0] : 1'b0;
        @(negedge clk);
        g = model_pick();
        exp_rdy = (g >= 0) ? (4'd1 << g) : 4'd0;
        rdy = {dma_req_in_ready, req_in_ready, rsp_in_ready, rst_tb_ready};
        last_ready = rdy;
        checks++;
        if (rdy !== exp_rdy) begin
            failures++;
            $display("FAIL ready t=%0t got=%b exp=%b", $time, rdy, exp_rdy);
        end
        checks++;
        if (out_valid !== m_valid) begin
            failures++;
            $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, m_valid);
        end
        checks++;
        if (out_sel !== 2'(m_sel)) begin
            failures++;
            $display("FAIL out_sel t=%0t got=%0d exp=%0d", $time, out_sel, m_sel);
        end
        checks++;
        if (out_last !== m_last) begin
            failures++;
            $display("FAIL out_last t=%0t got=%b exp=%b", $time, out_last, m_last);
        end
        checks++;
        if (dma_locked !== (m_mode == 1)) begin
            failures++;
            $display("FAIL dma_locked t=%0t got=%b exp=%b", $time, dma_locked, m_mode == 1);
        end
        checks++;
        if (dut.starve_cnt !== 4'(m_cnt)) begin
            failures++;
            $display("FAIL starve_cnt t=%0t got=%0d exp=%0d", $time, dut.starve_cnt, m_cnt);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) obs_q.push_back(int'(out_sel));
        @(posedge clk);
        model_update(g);
        case (g)
            0: n_rst--;
            1: n_rsp--;
            2: n_req--;
            3: void'(dma_q.pop_front());
            default: ;
        endcase
        #1;
    endtask

    task automatic check_obs(input string name, input int exp_q[$]);
        int got;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : -1;
            checks++;
            if (got != exp_q[i]) begin
                failures++;
                $display("FAIL %s[%0d] got sel=%0d exp sel=%0d", name, i, got, exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
        end
    endtask

    task automatic do_reset();
        n_rst = 0; n_rsp = 0; n_req = 0; dma_q.delete();
        out_ready = 1'b1; req_stall = 1'b0; rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_reset();
        n_rst = 1; n_rsp = 1; n_req = 1; dma_q = '{1'b1};
        out_ready = 1'b1; req_stall = 1'b0; rst = 1'b1;
        cycle(); cycle();
        checks++;
        if (last_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0000", last_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || dma_locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b sel=%0d lock=%b exp 0/0/0", out_valid, out_sel, dma_locked);
        end
        n_rst = 0; n_rsp = 0; dma_q.delete();
        rst = 1'b0;
        cycle();
        checks++;
        if (last_ready !== 4'b0100) begin
            failures++;
            $display("FAIL first_grant_after_reset got=%b exp=0100", last_ready);
        end
        cycle();
    endtask

    task automatic test_priority();
        do_reset();
        n_rst = 1; n_rsp = 1; n_req = 1; dma_q = '{1'b1};
        repeat (8) cycle();
        check_obs("priority", '{0, 1, 2, 3});
    endtask

    task automatic test_starve();
        do_reset();
        n_req = 6; dma_q = '{1'b1};
        repeat (9) cycle();
        check_obs("starve", '{2, 2, 2, 2, 3, 2, 2});
    endtask

    task automatic test_burst();
        do_reset();
        dma_q = '{1'b0, 1'b0, 1'b1};
        cycle();
        n_req = 2;
        repeat (6) cycle();
        check_obs("burst", '{3, 3, 3, 2, 2});
    endtask

    task automatic test_rsp_in_burst();
        do_reset();
        dma_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        cycle();
        n_rsp = 1;
        cycle();
        checks++;
        if (dma_locked !== 1'b1) begin
            failures++;
            $display("FAIL rsp_burst_locked got=%b exp=1", dma_locked);
        end
        repeat (6) cycle();
        check_obs("rsp_burst", '{3, 1, 3, 3, 3});
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        n_req = 1;
        cycle();
        n_rsp = 1;
        repeat (5) begin
            cycle();
            checks++;
            if (last_ready !== 4'b0000 || out_valid !== 1'b1 || out_sel !== 2'd2) begin
                failures++;
                $display("FAIL backpressure_hold got rdy=%b v=%b sel=%0d exp 0000/1/2",
                         last_ready, out_valid, out_sel);
            end
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (last_ready !== 4'b0010) begin
            failures++;
            $display("FAIL load_while_drain got=%b exp=0010", last_ready);
        end
        repeat (2) cycle();
        check_obs("backpressure", '{2, 1});
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        dma_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cycle(); cycle();
        checks++;
        if (out_valid !== 1'b1 || dma_locked !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_burst got v=%b lock=%b exp 1/1", out_valid, dma_locked);
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (last_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_ready got=%b exp=0000", last_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || dma_locked !== 1'b0 || dut.starve_cnt !== 4'd0) begin
            failures++;
            $display("FAIL post_reset got v=%b lock=%b cnt=%0d exp 0/0/0",
                     out_valid, dma_locked, dut.starve_cnt);
        end
        rst = 1'b0;
        dma_q.delete();
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        repeat (3000) begin
            if (n_rst == 0 && $urandom_range(0, 19) == 0) n_rst = 1;
            if (n_rsp < 3 && $urandom_range(0, 4) == 0) n_rsp++;
            if (n_req < 4 && $urandom_range(0, 2) == 0) n_req++;
            if (dma_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int i = 0; i < len; i++) dma_q.push_back(i == len - 1);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            req_stall = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; req_stall = 1'b0;
        rst_tb_valid = 1'b0; rsp_in_valid = 1'b0; req_in_valid = 1'b0;
        dma_req_in_valid = 1'b0; dma_last = 1'b0;
        m_mode = 0; m_cnt = 0; m_sel = 0; m_valid = 0; m_last = 0;
        n_rst = 0; n_rsp = 0; n_req = 0;
        #1;
        test_reset();
        test_priority();
        test_starve();
        test_burst();
        test_rsp_in_burst();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
